// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for the asynchronous FIFO: binary/Gray write pointer,
// read-pointer synchronizer, registered FULL/ALMOST_FULL/W_LEVEL and optional
// sticky OVERFLOW (enabled by defining FIFO_WR_OVF_EN).
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  W_CLK,
    input  logic                  W_RST,
    input  logic                  W_INC,
    input  logic [ADDR_WIDTH:0]   R_PTR,
    input  logic                  OVF_CLR,
    output logic                  W_EN,
    output logic [ADDR_WIDTH-1:0] W_ADDR,
    output logic [ADDR_WIDTH:0]   W_PTR,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic [ADDR_WIDTH:0]   W_LEVEL,
    output logic                  OVERFLOW
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_P   = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] rq;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          afull_next;

    assign W_EN   = W_INC & ~FULL;
    assign W_ADDR = wbin[ADDR_WIDTH-1:0];

    // Read pointer is only ever observed through the synchronizer, so level is pessimistic.
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= R_PTR;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rq = sync_q[SYNC_STAGES-1];

    always_comb begin
        wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, W_EN};
        wgray_next = wbin_next ^ (wbin_next >> 1);
        rbin       = gray_to_bin(rq);
        level_next = wbin_next - rbin;
        full_next  = (wgray_next == (rq ^ FULL_MASK));
        afull_next = (level_next >= AFULL_P);
    end

    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            wbin        <= '0;
            W_PTR       <= '0;
            W_LEVEL     <= '0;
            FULL        <= 1'b0;
            ALMOST_FULL <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            W_PTR       <= wgray_next;
            W_LEVEL     <= level_next;
            FULL        <= full_next;
            ALMOST_FULL <= afull_next;
        end
    end

`ifdef FIFO_WR_OVF_EN
    // Set has priority over clear so a blocked write is never lost.
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            OVERFLOW <= 1'b0;
        end else if (W_INC && FULL) begin
            OVERFLOW <= 1'b1;
        end else if (OVF_CLR) begin
            OVERFLOW <= 1'b0;
        end
    end
`else
    logic ovf_clr_unused;
    assign ovf_clr_unused = OVF_CLR;
    assign OVERFLOW       = 1'b0;
`endif

endmodule
